// File: rtl/codec_source_arbiter_pkg.sv
// Shared types for the codec source arbiter: fade state encoding and
// the source identifiers used on active_src.
package codec_source_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWAP     = 2'd2,
    ST_FADE_IN  = 2'd3
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/sample_gain_scaler.sv
// Combinational fade multiplier: signed sample times unsigned gain,
// arithmetic shift by GAIN_BITS (floor rounding), truncated to WIDTH.
module sample_gain_scaler #(
  parameter int WIDTH     = 16,
  parameter int GAIN_BITS = 6
) (
  input  logic signed [WIDTH-1:0] sample,
  input  logic        [GAIN_BITS:0] gain,
  output logic signed [WIDTH-1:0] scaled
);

  localparam int PW = WIDTH + GAIN_BITS + 1;

  // Full-width product: the zero-extended gain keeps the multiply signed
  // without letting unity gain look negative.
  logic signed [PW-1:0] product;

  // Multiply then shift; unity gain (2^GAIN_BITS) is a bit-exact pass-through.
  always_comb begin
    product = sample * $signed({1'b0, gain});
    scaled  = WIDTH'(product >>> GAIN_BITS);
  end

endmodule

// File: rtl/codec_source_arbiter.sv
// Click-free switch between two playback sources feeding the AC97 path.
// A mode change fades the active source out one step per codec frame,
// spends one zero-gain frame swapping player resets, then fades the new
// source in. The FSM state is visible on dbg_state.
//
// Strobes: new_sample_a/new_sample_b/new_frame are single-cycle pulses with
// no back-pressure; sample_valid is a single-cycle pulse in the cycle after
// new_frame, and sample_out holds its value until the next frame.
module codec_source_arbiter
  import codec_source_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int GAIN_BITS = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode_sel,
  input  logic [WIDTH-1:0] sample_a,
  input  logic             new_sample_a,
  input  logic [WIDTH-1:0] sample_b,
  input  logic             new_sample_b,
  input  logic             new_frame,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             src_reset_a,
  output logic             src_reset_b,
  output logic             active_src,
  output logic             fading,
  output logic [1:0]       dbg_state
);

  localparam logic [GAIN_BITS:0] UNITY = {1'b1, {GAIN_BITS{1'b0}}};

  logic             msel_meta_q, msel_meta_d;
  logic             msel_s_q, msel_s_d;
  logic [WIDTH-1:0] hold_a_q, hold_a_d;
  logic [WIDTH-1:0] hold_b_q, hold_b_d;
  arb_state_e       state_q, state_d;
  logic [GAIN_BITS:0] gain_q, gain_d;
  logic             active_q, active_d;
  logic             src_reset_a_q, src_reset_a_d;
  logic             src_reset_b_q, src_reset_b_d;
  logic [WIDTH-1:0] sample_out_q, sample_out_d;
  logic             sample_valid_q, sample_valid_d;

  logic [GAIN_BITS:0] gain_dec, gain_inc;
  logic [WIDTH-1:0]   scaled;

  // Synchronizer stages and sample holding registers.
  always_comb begin
    msel_meta_d = mode_sel;
    msel_s_d    = msel_meta_q;
    hold_a_d    = new_sample_a ? sample_a : hold_a_q;
    hold_b_d    = new_sample_b ? sample_b : hold_b_q;
  end

  // Fade state machine: advances only on a frame strobe; gain saturates at 0 and unity.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    active_d = active_q;
    gain_dec = (gain_q == '0) ? '0 : gain_q - 1'b1;
    gain_inc = (gain_q >= UNITY) ? UNITY : gain_q + 1'b1;
    if (new_frame) begin
      case (state_q)
        ST_PLAY: begin
          gain_d = UNITY;
          if (msel_s_q != active_q) state_d = ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          if (msel_s_q == active_q) begin
            state_d = ST_FADE_IN;
          end else begin
            gain_d = gain_dec;
            if (gain_dec == '0) begin
              state_d  = ST_SWAP;
              active_d = ~active_q;
            end
          end
        end
        ST_SWAP: begin
          gain_d  = '0;
          state_d = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (msel_s_q != active_q) begin
            state_d = ST_FADE_OUT;
          end else begin
            gain_d = gain_inc;
            if (gain_inc == UNITY) state_d = ST_PLAY;
          end
        end
        default: state_d = ST_PLAY;
      endcase
    end
  end

  // Player resets follow the routed source: exactly one player runs at a time.
  always_comb begin
    src_reset_a_d = (active_d != SRC_A);
    src_reset_b_d = (active_d != SRC_B);
  end

  sample_gain_scaler #(
    .WIDTH     (WIDTH),
    .GAIN_BITS (GAIN_BITS)
  ) u_scaler (
    .sample (active_q ? hold_b_q : hold_a_q),
    .gain   (gain_d),
    .scaled (scaled)
  );

  // Output register: refreshed once per frame with the holds as they were before this edge.
  always_comb begin
    sample_valid_d = new_frame;
    sample_out_d   = new_frame ? scaled : sample_out_q;
  end

  // All state flops, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msel_meta_q    <= 1'b0;
      msel_s_q       <= 1'b0;
      hold_a_q       <= '0;
      hold_b_q       <= '0;
      state_q        <= ST_PLAY;
      gain_q         <= UNITY;
      active_q       <= SRC_A;
      src_reset_a_q  <= 1'b0;
      src_reset_b_q  <= 1'b1;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      msel_meta_q    <= msel_meta_d;
      msel_s_q       <= msel_s_d;
      hold_a_q       <= hold_a_d;
      hold_b_q       <= hold_b_d;
      state_q        <= state_d;
      gain_q         <= gain_d;
      active_q       <= active_d;
      src_reset_a_q  <= src_reset_a_d;
      src_reset_b_q  <= src_reset_b_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign src_reset_a  = src_reset_a_q;
  assign src_reset_b  = src_reset_b_q;
  assign active_src   = active_q;
  assign fading       = (state_q != ST_PLAY);
  assign dbg_state    = state_q;

endmodule
